// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
//   Shared definitions for the bit-serial adder controller.
//   - FSM state encoding (legacy-compatible 2-bit localparams)
//   - Legal operand-width range plus a helper that checks a width against it
// Optional feature macro used by the users of this package: SERIAL_ADD_SUB_EN
// -----------------------------------------------------------------------------
package serial_add_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam int unsigned WIDTH_MIN = 32'd2;
   localparam int unsigned WIDTH_MAX = 32'd64;

   // True when w lies within the supported operand-width range.
   function automatic bit width_legal(input int unsigned w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

endpackage

// File: rtl/serial_full_add_cell.sv
// -----------------------------------------------------------------------------
// half_adder / serial_full_add_cell
//   Purely combinational 1-bit full adder built from two half adders and an OR.
//   The bit-serial controller drives it once per clock.
// Ports (serial_full_add_cell):
//   a, b   in  1  operand bits
//   cin    in  1  carry in
//   sum    out 1  sum bit
//   cout   out 1  carry out
// -----------------------------------------------------------------------------
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b;
   assign carry = a & b;
endmodule

module serial_full_add_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   logic s1;
   logic c1;
   logic c2;

   half_adder u_ha0 (.a(a),  .b(b),   .sum(s1),  .carry(c1));
   half_adder u_ha1 (.a(s1), .b(cin), .sum(sum), .carry(c2));

   // At most one of the two half-adder carries can be set, so OR is exact.
   assign cout = c1 | c2;
endmodule

// File: rtl/serial_add_sequencer.sv
// -----------------------------------------------------------------------------
// serial_add_sequencer
//   Bit-serial adder controller. Latches two WIDTH-bit operands on the accept
//   edge, then adds one bit per clock (LSB first) through a single full-add
//   cell. The result is offered through a valid/ready handshake.
//   Latency: result_valid_out rises WIDTH edges after the accept edge.
// Parameters:
//   WIDTH  operand/result width (2..64)
//   CNT_W  bit-index counter width, derived from WIDTH
// Ports:
//   clk_in            in   1      clock, rising edge
//   rst_in            in   1      asynchronous active-high reset
//   start_in          in   1      request, accepted only while ready_out=1
//   a_in, b_in        in   WIDTH  operands, sampled on the accept edge
//   carry_in          in   1      initial carry, sampled on the accept edge
//   sub_in            in   1      (SERIAL_ADD_SUB_EN only) 1 = compute a_in-b_in
//   ready_out         out  1      high in IDLE only
//   sum_out           out  WIDTH  result, stable while result_valid_out=1
//   carry_out         out  1      carry out of bit WIDTH-1 (1 = no borrow when subtracting)
//   result_valid_out  out  1      result available
//   result_ready_in   in   1      consumer takes the result
// Configuration macro: SERIAL_ADD_SUB_EN (adds sub_in and subtraction)
// -----------------------------------------------------------------------------
module serial_add_sequencer
   import serial_add_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             carry_in,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub_in,
`endif
   output logic             ready_out,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
   output logic             result_valid_out,
   input  logic             result_ready_in
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             c;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] sum_reg;
   logic             carry_reg;
   logic             ready_reg;
   logic             valid_reg;

   logic [WIDTH-1:0] b_load;
   logic             c_load;
   logic             bit_sum;
   logic             bit_cout;

   // Operand B and initial carry as they are latched on the accept edge.
   always_comb begin
      b_load = b_in;
      c_load = carry_in;
`ifdef SERIAL_ADD_SUB_EN
      // A - B = A + ~B + 1; the caller's carry_in does not apply.
      if (sub_in) begin
         b_load = ~b_in;
         c_load = 1'b1;
      end else begin
         b_load = b_in;
         c_load = carry_in;
      end
`endif
   end

   serial_full_add_cell u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (c),
      .sum  (bit_sum),
      .cout (bit_cout)
   );

   // Control FSM, bit counter, operand shifters and result registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state     <= S_IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         c         <= 1'b0;
         count     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         ready_reg <= 1'b1;
         valid_reg <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_in) begin
                  a_sh      <= a_in;
                  b_sh      <= b_load;
                  c         <= c_load;
                  count     <= '0;
                  ready_reg <= 1'b0;
                  state     <= S_SHIFT;
               end else begin
                  ready_reg <= 1'b1;
               end
            end
            S_SHIFT: begin
               // Sum bits enter at the MSB; after WIDTH shifts bit 0 sits at the LSB.
               sum_reg <= {bit_sum, sum_reg[WIDTH-1:1]};
               a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
               c       <= bit_cout;
               count   <= count + CNT_W'(1);
               if (count == LAST_BIT) begin
                  carry_reg <= bit_cout;
                  valid_reg <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  state     <= S_SHIFT;
               end
            end
            S_DONE: begin
               // A start arriving together with result_ready_in is not accepted.
               if (result_ready_in) begin
                  valid_reg <= 1'b0;
                  ready_reg <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  valid_reg <= 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               ready_reg <= 1'b1;
               valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign ready_out        = ready_reg;
   assign sum_out          = sum_reg;
   assign carry_out        = carry_reg;
   assign result_valid_out = valid_reg;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sequencer
//   Self-checking bench for serial_add_sequencer at WIDTH=8: a table of
//   directed add (and, with SERIAL_ADD_SUB_EN, subtract) vectors plus
//   hand-written sequences for ignored starts, result back-pressure,
//   simultaneous start/result_ready, and reset mid-operation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_add_sequencer;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] exp_sum;
      logic         exp_carry;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         ready;
   logic [W-1:0] sum;
   logic         carry;
   logic         valid;
   logic         rready = 1'b0;

   int checks = 0;
   int errors = 0;

   vec_t vecs [12];
   int   n_vec;

   serial_add_sequencer #(.WIDTH(W)) dut (
      .clk_in           (clk),
      .rst_in           (rst),
      .start_in         (start),
      .a_in             (a),
      .b_in             (b),
      .carry_in         (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub_in           (sub),
`endif
      .ready_out        (ready),
      .sum_out          (sum),
      .carry_out        (carry),
      .result_valid_out (valid),
      .result_ready_in  (rready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One complete operation. ignore_at: cycle after accept at which a rival
   // start is pulsed (-1 = none). hold: cycles to keep result_ready low in DONE.
   task automatic run_op(input vec_t v, input int ignore_at, input int hold, input string name);
      int lat;
      int ready_high;
      @(negedge clk);
      a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // Operand changes after acceptance must not matter.
      a = ~v.a; b = v.b ^ 8'h5A; cin = ~v.cin; sub = ~v.sub;
      lat = 0;
      ready_high = 0;
      while (!valid && lat < 20) begin
         if (ready) ready_high++;
         if (lat == ignore_at) begin
            start = 1'b1; a = 8'hAA; b = 8'h55;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check({name, " latency"}, lat, 8);
      check({name, " ready_low"}, ready_high, 0);
      check({name, " sum"}, sum, v.exp_sum);
      check({name, " carry"}, carry, v.exp_carry);
      check({name, " ready_in_done"}, ready, 1'b0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({name, " hold_valid"}, valid, 1'b1);
         check({name, " hold_sum"}, sum, v.exp_sum);
         check({name, " hold_carry"}, carry, v.exp_carry);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      check({name, " post_ready"}, ready, 1'b1);
      check({name, " post_valid"}, valid, 1'b0);
   endtask

   initial begin
      vec_t v;
      int   lat;
      vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'h7F, 8'h80, 1'b1, 1'b0, 8'h00, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
      vecs[4] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
      vecs[5] = '{8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0};
      vecs[6] = '{8'h3C, 8'hC4, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[7] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0};
      n_vec = 8;
`ifdef SERIAL_ADD_SUB_EN
      vecs[8]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0};
      vecs[9]  = '{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1};
      vecs[10] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
      vecs[11] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1};
      n_vec = 12;
`endif

      // Reset state.
      #12;
      check("reset ready", ready, 1'b1);
      check("reset sum", sum, 8'h00);
      check("reset carry", carry, 1'b0);
      check("reset valid", valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven vectors.
      for (int i = 0; i < n_vec; i++) begin
         run_op(vecs[i], -1, 0, $sformatf("vec%0d", i));
      end

      // Rival start pulsed during SHIFT is ignored.
      run_op(vecs[0], 3, 0, "ignored_start");
      @(negedge clk);
      check("ignored_start idle", ready, 1'b1);
      check("ignored_start no_op", valid, 1'b0);

      // Result back-pressure for 5 cycles.
      run_op(vecs[1], -1, 5, "hold");

      // start together with result_ready in DONE: only DONE->IDLE.
      v = '{8'h21, 8'h10, 1'b0, 1'b0, 8'h31, 1'b0};
      @(negedge clk);
      a = v.a; b = v.b; cin = v.cin; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("simul latency", lat, 8);
      check("simul sum", sum, v.exp_sum);
      start = 1'b1; rready = 1'b1;
      @(negedge clk);
      start = 1'b0; rready = 1'b0;
      check("simul ready", ready, 1'b1);
      check("simul valid", valid, 1'b0);
      repeat (3) @(negedge clk);
      check("simul not_accepted", ready, 1'b1);

      // Reset at count=4 aborts the operation.
      @(negedge clk);
      a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("abort busy", ready, 1'b0);
      rst = 1'b1;
      #1;
      check("abort ready", ready, 1'b1);
      check("abort sum", sum, 8'h00);
      check("abort carry", carry, 1'b0);
      check("abort valid", valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      run_op('{8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0}, -1, 0, "after_abort");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
